// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: request/response link between the HI/LO controller and the
// multiply/divide unit.
//   md_funct      request funct (MULT/MULTU/DIV/DIVU), 0 when idle
//   md_operand_1  rs operand
//   md_operand_2  rt operand
//   md_flush      clears the unit's cycle counter
//   md_done       one-cycle completion pulse from the unit
//   md_result     {HI, LO}; valid only while md_done is high
// master = controller side, slave = mult/div unit side.
interface hilo_ctrl_if;
   logic [5:0]  md_funct;
   logic [31:0] md_operand_1;
   logic [31:0] md_operand_2;
   logic        md_flush;
   logic        md_done;
   logic [63:0] md_result;

   modport master (
      output md_funct,
      output md_operand_1,
      output md_operand_2,
      output md_flush,
      input  md_done,
      input  md_result
   );

   modport slave (
      input  md_funct,
      input  md_operand_1,
      input  md_operand_2,
      input  md_flush,
      output md_done,
      output md_result
   );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage initiator for the multiply/divide unit and owner of the
// architectural HI/LO registers.
//   clk, rst     clock; synchronous active-high reset
//   flush        kills the EX instruction
//   op_valid     EX holds a SPECIAL-class instruction
//   op_funct     its funct field
//   op_a, op_b   forwarded rs / rt values
//   ex_advance   EX instruction leaves EX at this edge
//   stall_req    hold the pipeline (combinational)
//   md           request/response link to the mult/div unit (master side)
//   hilo_rdata   HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo       architectural HI / LO registers
module hilo_ctrl (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             op_valid,
   input  logic [5:0]       op_funct,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   input  logic             ex_advance,
   output logic             stall_req,
   hilo_ctrl_if.master      md,
   output logic [31:0]      hilo_rdata,
   output logic [31:0]      hi,
   output logic [31:0]      lo
);

   localparam logic [5:0] FunctMfhi  = 6'h10;
   localparam logic [5:0] FunctMthi  = 6'h11;
   localparam logic [5:0] FunctMflo  = 6'h12;
   localparam logic [5:0] FunctMtlo  = 6'h13;
   localparam logic [5:0] FunctMult  = 6'h18;
   localparam logic [5:0] FunctMultu = 6'h19;
   localparam logic [5:0] FunctDiv   = 6'h1A;
   localparam logic [5:0] FunctDivu  = 6'h1B;

   // StHold: result already captured, waiting for the instruction to leave EX.
   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e      state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        md_op;
   logic        issue;

   assign md_op = op_valid && ((op_funct == FunctMult) || (op_funct == FunctMultu) ||
                               (op_funct == FunctDiv)  || (op_funct == FunctDivu));

   // Gated by rst so outputs are quiet while reset is held, whatever EX holds.
   assign issue = !rst && (state_q == StIdle) && md_op;

   assign stall_req = issue && !md.md_done;

   // Dropping funct outside StIdle stops the unit from restarting once its
   // counter returns to zero, which would double-write HI/LO.
   assign md.md_funct     = (issue && !flush) ? op_funct : 6'd0;
   assign md.md_operand_1 = op_a;
   assign md.md_operand_2 = op_b;
   assign md.md_flush     = flush;

   always_comb begin
      hilo_rdata = 32'd0;
      if (op_funct == FunctMfhi) begin
         hilo_rdata = hi_q;
      end else if (op_funct == FunctMflo) begin
         hilo_rdata = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else if (flush) begin
         // A killed instruction never writes, even with md_done in this cycle.
         state_q <= StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (md_op && md.md_done) begin
                  hi_q <= md.md_result[63:32];
                  lo_q <= md.md_result[31:0];
                  if (!ex_advance) begin
                     state_q <= StHold;
                  end
               end
            end
            StHold: begin
               if (ex_advance) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (op_valid && ex_advance) begin
            if (op_funct == FunctMthi) begin
               hi_q <= op_a;
            end
            if (op_funct == FunctMtlo) begin
               lo_q <= op_a;
            end
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mult/div unit, HI/LO reference model and a
// queue-based scoreboard checked by an independent monitor process.
module tb_hilo_ctrl;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        op_valid;
   logic [5:0]  op_funct;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ex_advance;
   logic        stall_req;
   logic [31:0] hilo_rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   hilo_ctrl_if md ();

   hilo_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .op_valid   (op_valid),
      .op_funct   (op_funct),
      .op_a       (op_a),
      .op_b       (op_b),
      .ex_advance (ex_advance),
      .stall_req  (stall_req),
      .md         (md),
      .hilo_rdata (hilo_rdata),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] rdata;
      int          stalls;
      int          dones;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_hi;
   logic [31:0] ref_lo;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   function automatic bit is_md(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   function automatic bit is_div(input logic [5:0] f);
      return (f == F_DIV) || (f == F_DIVU);
   endfunction

   // Architectural result {HI, LO}. Divide by zero: this unit returns {rs, all-ones}.
   function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa;
      longint      sb_;
      int          q;
      int          r;
      logic [31:0] uq;
      logic [31:0] ur;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      case (f)
         F_MULT:  return 64'(sa * sb_);
         F_MULTU: return {32'd0, a} * {32'd0, b};
         F_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            uq = q;
            ur = r;
            return {ur, uq};
         end
         F_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Behavioural mult/div unit: latency 1 for multiply, 33 for divide.
   int unsigned u_cnt;
   logic [63:0] u_res;

   always @(posedge clk) begin
      if (rst || md.md_flush) begin
         u_cnt <= 0;
      end else if (u_cnt == 0 && is_md(md.md_funct)) begin
         u_cnt <= is_div(md.md_funct) ? 33 : 1;
         u_res <= ref_result(md.md_funct, md.md_operand_1, md.md_operand_2);
      end else if (u_cnt != 0) begin
         u_cnt <= u_cnt - 1;
      end
   end

   assign md.md_done   = (u_cnt == 1);
   assign md.md_result = md.md_done ? u_res : 64'h5A5A_5A5A_A5A5_A5A5;

   // Monitor: samples mid-cycle; compares per-instruction stall/done counts and
   // read data at retirement, then HI/LO one cycle later.
   initial begin
      bit   pending;
      exp_t pend;
      exp_t e;
      int   stalls;
      int   dones;
      pending = 0;
      stalls  = 0;
      dones   = 0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            pending = 0;
            stalls  = 0;
            dones   = 0;
         end else begin
            if (pending) begin
               chk($sformatf("hi f=%0h", pend.funct), 64'(hi), 64'(pend.hi));
               chk($sformatf("lo f=%0h", pend.funct), 64'(lo), 64'(pend.lo));
               pending = 0;
            end
            if (flush) begin
               stalls = 0;
               dones  = 0;
            end else begin
               if (op_valid && stall_req) stalls++;
               if (md.md_done) dones++;
               if (op_valid && ex_advance) begin
                  if (sb.size() == 0) begin
                     failures++;
                     $display("FAIL retire: got unexpected retirement expected none at %0t",
                              $time);
                  end else begin
                     e = sb.pop_front();
                     chk($sformatf("stall_cycles f=%0h", e.funct), 64'(stalls), 64'(e.stalls));
                     chk($sformatf("md_done_count f=%0h", e.funct), 64'(dones), 64'(e.dones));
                     chk($sformatf("hilo_rdata f=%0h", e.funct), 64'(hilo_rdata),
                         64'(e.rdata));
                     pend    = e;
                     pending = 1;
                  end
                  stalls = 0;
                  dones  = 0;
               end
            end
         end
      end
   end

   // Inputs change at negedge+1; stall_req is read at negedge+2.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      exp_t        e;
      logic [63:0] res;
      int          n;
      bit          first;
      bit          done;
      e.funct  = f;
      e.rdata  = 32'd0;
      e.stalls = 0;
      e.dones  = 0;
      if (is_md(f)) begin
         res      = ref_result(f, a, b);
         ref_hi   = res[63:32];
         ref_lo   = res[31:0];
         e.stalls = is_div(f) ? 33 : 1;
         e.dones  = 1;
      end else begin
         hold = 0;
         if (f == F_MTHI) ref_hi = a;
         if (f == F_MTLO) ref_lo = a;
         if (f == F_MFHI) e.rdata = ref_hi;
         if (f == F_MFLO) e.rdata = ref_lo;
      end
      e.hi = ref_hi;
      e.lo = ref_lo;
      sb.push_back(e);

      op_valid   = 1'b1;
      op_funct   = f;
      op_a       = a;
      op_b       = b;
      ex_advance = 1'b0;
      n     = 0;
      first = 1;
      done  = 0;
      while (!done) begin
         #1;
         if (stall_req) begin
            ex_advance = 1'b0;
            n++;
            if (n > 200) begin
               failures++;
               $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
               summary();
            end
            step();
         end else begin
            if (!first) chk("md_funct_in_hold", 64'(md.md_funct), 64'd0);
            if (hold > 0) begin
               hold--;
               first      = 0;
               ex_advance = 1'b0;
               step();
            end else begin
               ex_advance = 1'b1;
               step();
               ex_advance = 1'b0;
               op_valid   = 1'b0;
               done       = 1;
            end
         end
      end
   endtask

   task automatic do_flush_div(input logic [31:0] a, input logic [31:0] b);
      op_valid   = 1'b1;
      op_funct   = F_DIV;
      op_a       = a;
      op_b       = b;
      ex_advance = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      #1;
      chk("md_flush", 64'(md.md_flush), 64'd1);
      chk("md_funct_flush", 64'(md.md_funct), 64'd0);
      step();
      flush    = 1'b0;
      op_valid = 1'b0;
      #1;
      chk("hi_after_flush", 64'(hi), 64'(ref_hi));
      chk("lo_after_flush", 64'(lo), 64'(ref_lo));
      step();
      chk("md_done_after_flush", 64'(md.md_done), 64'd0);
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      summary();
   end

   initial begin
      logic [5:0]  fl [9];
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      fl = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_ADD};

      rst        = 1'b1;
      flush      = 1'b0;
      op_valid   = 1'b1;
      op_funct   = F_MULT;
      op_a       = 32'd3;
      op_b       = 32'd4;
      ex_advance = 1'b0;
      ref_hi     = 32'd0;
      ref_lo     = 32'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("reset_stall_req", 64'(stall_req), 64'd0);
         chk("reset_md_funct", 64'(md.md_funct), 64'd0);
         if (i == 1) begin
            chk("reset_hi", 64'(hi), 64'd0);
            chk("reset_lo", 64'(lo), 64'd0);
         end
      end
      rst      = 1'b0;
      op_valid = 1'b0;
      step();

      do_op(F_MULT, 32'hFFFFFFFD, 32'd5, 0);
      do_op(F_DIV, 32'd7, 32'hFFFFFFFE, 0);
      do_op(F_DIVU, 32'd100, 32'd7, 3);
      do_flush_div(32'd1000, 32'd3);
      do_op(F_MULT, 32'h12345678, 32'h9ABCDEF0, 0);
      do_op(F_MTLO, 32'hCAFEF00D, 32'd0, 0);
      do_op(F_MFLO, 32'd0, 32'd0, 0);
      do_op(F_MTHI, 32'h0BADBEEF, 32'd0, 0);
      do_op(F_MFHI, 32'd0, 32'd0, 0);
      do_op(F_DIV, 32'h80000123, 32'd0, 1);
      do_op(F_ADD, 32'd1, 32'd2, 0);
      do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      do_op(F_DIVU, 32'hFFFFFFFF, 32'd16, 0);

      for (int i = 0; i < 40; i++) begin
         f = fl[$urandom_range(0, 8)];
         a = $urandom();
         b = $urandom();
         if (is_div(f)) begin
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         end
         if ($urandom_range(0, 3) == 0) begin
            op_valid = 1'b0;
            step();
         end
         do_op(f, a, b, $urandom_range(0, 2));
      end

      op_valid = 1'b0;
      repeat (3) step();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      summary();
   end

endmodule
